// File: rtl/sc_phase_gen.sv
// Non-overlapping two-phase clock generator (phi1/phi2 plus early phases) for NCH SC channels.
// Optional build macro SC_PHASE_INTERLEAVE_EN: odd channels get swapped phases, settle twice/frame.
module sc_phase_gen #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RST_HALF = 8,
  parameter int unsigned RST_DEAD = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cfg_half,
  input  logic [CNT_W-1:0] i_cfg_dead,
  input  logic [NCH-1:0]   i_cfg_mask,
  input  logic             i_cfg_load,
  output logic             o_cfg_ack,
  output logic [NCH-1:0]   o_phi1,
  output logic [NCH-1:0]   o_phi1e,
  output logic [NCH-1:0]   o_phi2,
  output logic [NCH-1:0]   o_phi2e,
  output logic             o_settle,
  output logic             o_busy
);

`ifdef SC_PHASE_INTERLEAVE_EN
  localparam bit IntlvEn = 1'b1;
`else
  localparam bit IntlvEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MinHalf  = CNT_W'(2);
  localparam logic [CNT_W-1:0] MinDead  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RstHalfC = (RST_HALF < 2) ? CNT_W'(2) : CNT_W'(RST_HALF);
  localparam logic [CNT_W-1:0] RstDeadC = (RST_DEAD < 1) ? CNT_W'(1) : CNT_W'(RST_DEAD);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StP1, StD12, StP2, StD21} state_e;

  function automatic logic [CNT_W-1:0] f_clamp(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lo);
    return (v < lo) ? lo : v;
  endfunction

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Active configuration, only ever changed at a frame boundary or in idle
  logic [CNT_W-1:0] r_half, r_dead;
  logic [NCH-1:0]   r_mask;
  logic [CNT_W-1:0] r_sh_half, r_sh_dead;
  logic [NCH-1:0]   r_sh_mask;
  logic             r_sh_valid;

  logic             r_cfg_ack;
  logic [NCH-1:0]   r_phi1, r_phi1e, r_phi2, r_phi2e;
  logic             r_settle;

  logic             w_frame_end;
  logic             w_apply;
  logic [CNT_W-1:0] w_half_nxt, w_dead_nxt;
  logic [NCH-1:0]   w_mask_nxt;
  logic             w_in_p1, w_in_p1e, w_in_p2, w_in_p2e;
  logic [NCH-1:0]   w_phi1, w_phi1e, w_phi2, w_phi2e;
  logic             w_settle;

  assign w_frame_end = (r_state == StD21) && (r_cnt == '0);
  assign w_apply     = r_sh_valid && ((r_state == StIdle) || w_frame_end);
  assign w_half_nxt  = w_apply ? r_sh_half : r_half;
  assign w_dead_nxt  = w_apply ? r_sh_dead : r_dead;
  assign w_mask_nxt  = w_apply ? r_sh_mask : r_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_en) begin
          w_state_nxt = StP1;
          w_cnt_nxt   = w_half_nxt - CntOne;
        end
      end
      StP1: begin
        if (r_cnt == '0) begin
          w_state_nxt = StD12;
          w_cnt_nxt   = r_dead - CntOne;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      StD12: begin
        if (r_cnt == '0) begin
          w_state_nxt = StP2;
          w_cnt_nxt   = r_half - CntOne;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      StP2: begin
        if (r_cnt == '0) begin
          w_state_nxt = StD21;
          w_cnt_nxt   = r_dead - CntOne;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      StD21: begin
        if (r_cnt == '0) begin
          w_state_nxt = i_en ? StP1 : StIdle;
          w_cnt_nxt   = i_en ? (w_half_nxt - CntOne) : '0;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state so they register in step with the FSM
  assign w_in_p1  = (w_state_nxt == StP1);
  assign w_in_p1e = w_in_p1 && (w_cnt_nxt != '0);
  assign w_in_p2  = (w_state_nxt == StP2);
  assign w_in_p2e = w_in_p2 && (w_cnt_nxt != '0);

  always_comb begin
    w_phi1  = '0;
    w_phi1e = '0;
    w_phi2  = '0;
    w_phi2e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (IntlvEn && (c % 2 == 1)) begin
        w_phi1[c]  = w_mask_nxt[c] & w_in_p2;
        w_phi1e[c] = w_mask_nxt[c] & w_in_p2e;
        w_phi2[c]  = w_mask_nxt[c] & w_in_p1;
        w_phi2e[c] = w_mask_nxt[c] & w_in_p1e;
      end else begin
        w_phi1[c]  = w_mask_nxt[c] & w_in_p1;
        w_phi1e[c] = w_mask_nxt[c] & w_in_p1e;
        w_phi2[c]  = w_mask_nxt[c] & w_in_p2;
        w_phi2e[c] = w_mask_nxt[c] & w_in_p2e;
      end
    end
  end

  always_comb begin
    w_settle = (w_state_nxt == StD21) && (r_state != StD21);
    if (IntlvEn) begin
      w_settle = w_settle || ((w_state_nxt == StD12) && (r_state != StD12));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A load coinciding with application keeps the new value pending for the next boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_half     <= RstHalfC;
      r_dead     <= RstDeadC;
      r_mask     <= '1;
      r_sh_half  <= RstHalfC;
      r_sh_dead  <= RstDeadC;
      r_sh_mask  <= '1;
      r_sh_valid <= 1'b0;
      r_cfg_ack  <= 1'b0;
    end else begin
      r_half    <= w_half_nxt;
      r_dead    <= w_dead_nxt;
      r_mask    <= w_mask_nxt;
      r_cfg_ack <= w_apply;
      if (i_cfg_load) begin
        r_sh_half  <= f_clamp(i_cfg_half, MinHalf);
        r_sh_dead  <= f_clamp(i_cfg_dead, MinDead);
        r_sh_mask  <= i_cfg_mask;
        r_sh_valid <= 1'b1;
      end else if (w_apply) begin
        r_sh_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phi1   <= '0;
      r_phi1e  <= '0;
      r_phi2   <= '0;
      r_phi2e  <= '0;
      r_settle <= 1'b0;
    end else begin
      r_phi1   <= w_phi1;
      r_phi1e  <= w_phi1e;
      r_phi2   <= w_phi2;
      r_phi2e  <= w_phi2e;
      r_settle <= w_settle;
    end
  end

  assign o_cfg_ack = r_cfg_ack;
  assign o_phi1    = r_phi1;
  assign o_phi1e   = r_phi1e;
  assign o_phi2    = r_phi2;
  assign o_phi2e   = r_phi2e;
  assign o_settle  = r_settle;
  assign o_busy    = (r_state != StIdle);

endmodule

// File: doc/sc_phase_gen.md
Name: sc_phase_gen

Overview:
- Programmable non-overlapping two-phase clock generator for the switched-capacitor filter array.
- Produces phi1/phi2 and early-phase phi1e/phi2e for bottom-plate sampling, for NCH filter channels.
- Provides per-channel masking and shadowed configuration applied only at frame boundaries.
- Emits a settle strobe to the downstream sampler each frame.

Parameters:
- NCH, 2, number of filter channels driven
- CNT_W, 8, width of half-period and dead-time counters
- RST_HALF, 8, half-phase length in clk cycles after reset
- RST_DEAD, 1, dead time in clk cycles after reset

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run request; level-sensitive
- cfg_half  input  CNT_W  requested phase-high length H
- cfg_dead  input  CNT_W  requested dead time D
- cfg_mask  input  NCH  requested channel enable mask (1 = active)
- cfg_load  input  1  one-cycle request to capture cfg_* into shadow
- cfg_ack  output  1  one-cycle pulse when shadow becomes active
- phi1  output  NCH  sampling phase (late edge)
- phi1e  output  NCH  early sampling phase (falls before phi1)
- phi2  output  NCH  integration phase (late edge)
- phi2e  output  NCH  early integration phase
- settle  output  1  one-cycle strobe at phi2 falling edge
- busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset: all phase outputs 0, cfg_ack=0, settle=0, busy=0, FSM=IDLE. Active config = {RST_HALF, RST_DEAD, all-ones mask}. Shadow invalid.
- Reset asserted mid-frame forces all outputs low on the same edge, with no dead-time completion.
- FSM states: IDLE, P1, D12, P2, D21.
- IDLE -> P1 when en=1, one-cycle latency from the first clk edge sampling en=1.
- P1 lasts H cycles, then D12 for D cycles.
- D12 is followed by P2 for H cycles, then D21 for D cycles.
- At the end of D21: go to P1 if en=1, else IDLE.
- Frame period = 2*(H+D) cycles.
- Clamping: effective H = max(cfg_half, 2); effective D = max(cfg_dead, 1). Phases never overlap and there is never a zero-dead-time frame.
- Outputs, for active channel c (all registered, glitch-free):
  - phi1[c]=1 for all H cycles of P1.
  - phi1e[c]=1 for the first H-1 cycles of P1, so it falls exactly one cycle before phi1.
  - phi2 and phi2e follow the same rule in P2.
- Masked channels (mask bit 0) hold all four phase outputs at 0.
- settle pulses for one cycle on the first cycle of D21.
- en deassertion mid-frame is graceful: the current frame runs to the end of D21, then the FSM enters IDLE. busy stays high until IDLE is reached.
- Config handshake:
  - cfg_load=1 captures cfg_half, cfg_dead and cfg_mask into the shadow and sets shadow-valid.
  - A second cfg_load before application overwrites the shadow; the last value wins and only one ack is issued.
  - The shadow is applied at the D21->P1 or D21->IDLE transition. In IDLE it is applied on the next cycle.
  - cfg_ack pulses the cycle the new config takes effect; shadow-valid then clears.
  - If cfg_load coincides with the application cycle, the new value is kept in the shadow and applied at the next boundary, with its own ack.
- Counter: down-counter CNT_W bits, loaded with H-1 or D-1 on state entry; the state transitions when it reaches 0. No wrap-around is possible.

Optional Feature:
- Macro SC_PHASE_INTERLEAVE_EN.
- Defined: odd-indexed channels receive swapped phases (phi1<->phi2, phi1e<->phi2e) for ping-pong double sampling. settle then also pulses on the first cycle of D12.
- Undefined: all channels are in phase and settle pulses only in D21.

Test Plan:
- Reset, en=1, default config -> phi1 rises 1 cycle after en is sampled; phi1 high 8, dead 1, phi2 high 8, dead 1; period 18; phi1e falls 1 cycle before phi1.
- cfg_half=0, cfg_dead=0, cfg_load in IDLE -> cfg_ack next cycle; run gives H=2, D=1, period 6, and no cycle with phi1 and phi2 both high.
- Mid-P2, cfg_load with half=4, dead=2, mask=2'b10 -> current frame unchanged; cfg_ack at frame boundary; next frame period 12 with channel 0 outputs all 0.
- en dropped during P1 -> frame completes through D21 with one settle pulse; then IDLE, busy=0, all outputs 0.
- rst asserted during P2 -> phi2, phi2e and busy go 0 immediately (async); after release with en=1, operation restarts at P1 with reset config.
- With SC_PHASE_INTERLEAVE_EN, NCH=2 -> phi1[1]==phi2[0] every cycle; settle pulses twice per frame.
